// File: rtl/memory_stage_pkg.sv
// Shared encodings and types for the MEM stage: access sizes, FSM states and
// the MEM/WB bundle layout.
package memory_stage_pkg;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b10;

  // Wide enough for the largest supported TIMEOUT_CYCLES (255).
  localparam int TIMEOUT_CNT_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [1:0]  jump;
    logic [31:0] alu;
    logic [31:0] read_data;
    logic [4:0]  dest;
    logic [31:0] pc_link;
  } wb_bundle_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: store strobes/replicated data, alignment check,
// and load byte/half extraction with zero or sign extension.
module load_store_align
  import memory_stage_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  output logic        misaligned,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_signed,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_bytes [4];
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_bytes[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  // Reserved size 2'b11 falls into the default branch and behaves as a word.
  always_comb begin
    byte_en    = 4'b1111;
    wdata      = st_data;
    misaligned = (st_lane != 2'b00);
    case (st_size)
      MEM_SIZE_HALF: begin
        byte_en    = st_lane[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{st_data[15:0]}};
        misaligned = st_lane[0];
      end
      MEM_SIZE_BYTE: begin
        byte_en    = 4'b0001 << st_lane;
        wdata      = {4{st_data[7:0]}};
        misaligned = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    ld_byte   = lane_bytes[ld_lane];
    ld_half   = ld_lane[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (ld_size)
      MEM_SIZE_HALF: load_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      MEM_SIZE_BYTE: load_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      default:       load_data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage with MEM/WB pipeline register: issues one req/ack data-memory access
// per load/store, stalls upstream while it is outstanding, aborts on timeout.
module memory_access_stage
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ValidIn,
  input  logic        FlushIn,
  input  logic        RegWriteIn,
  input  logic        MemToRegIn,
  input  logic [1:0]  JumpIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  MemSizeIn,
  input  logic        MemSignedIn,
  input  logic [31:0] ALUIn,
  input  logic [31:0] StoreDataIn,
  input  logic [4:0]  DestinationRegIn,
  input  logic [31:0] PCValueForJALIn,
  output logic        StallOut,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemByteEn,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        RegWriteOut,
  output logic        MemToRegOut,
  output logic [1:0]  JumpOut,
  output logic [31:0] ALUOut,
  output logic [31:0] MemoryReadDataOut,
  output logic [4:0]  DestinationRegOut,
  output logic [31:0] PCValueForJALOut,
  output logic        AlignErrOut,
  output logic        BusErrOut
);

  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                   state_reg;
  logic [TIMEOUT_CNT_W-1:0] timeout_cnt_reg;
  wb_bundle_t               wb_reg;
  wb_bundle_t               in_bundle;
  logic                     mem_req_reg;
  logic                     mem_we_reg;
  logic [31:0]              mem_addr_reg;
  logic [31:0]              mem_wdata_reg;
  logic [3:0]               mem_byte_en_reg;
  logic [1:0]               ld_size_reg;
  logic [1:0]               ld_lane_reg;
  logic                     ld_signed_reg;
  logic                     align_err_reg;
  logic                     bus_err_reg;

  logic        memop;
  logic        misaligned;
  logic        timeout_hit;
  logic [3:0]  st_byte_en;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign memop       = ValidIn & ~FlushIn & (MemReadIn | MemWriteIn);
  assign timeout_hit = (state_reg == ACCESS) && !MemAck && (timeout_cnt_reg == TIMEOUT_LAST);

  load_store_align u_align (
    .st_size   (MemSizeIn),
    .st_lane   (ALUIn[1:0]),
    .st_data   (StoreDataIn),
    .byte_en   (st_byte_en),
    .wdata     (st_wdata),
    .misaligned(misaligned),
    .ld_size   (ld_size_reg),
    .ld_lane   (ld_lane_reg),
    .ld_signed (ld_signed_reg),
    .rdata     (MemRData),
    .load_data (ld_data)
  );

  // Flush only squashes in IDLE; once an access is in flight the held
  // instruction retires regardless.
  always_comb begin
    in_bundle.reg_write  = RegWriteIn & ValidIn & ((state_reg == ACCESS) | ~FlushIn);
    in_bundle.mem_to_reg = MemToRegIn;
    in_bundle.jump       = JumpIn;
    in_bundle.alu        = ALUIn;
    in_bundle.dest       = DestinationRegIn;
    in_bundle.pc_link    = PCValueForJALIn;
    in_bundle.read_data  = '0;
    if ((state_reg == ACCESS) && !mem_we_reg) begin
      in_bundle.read_data = ld_data;
    end
  end

  // The timeout cycle releases the stall so the aborted instruction drains.
  always_comb begin
    if (state_reg == ACCESS) begin
      StallOut = ~MemAck & ~timeout_hit;
    end else begin
      StallOut = memop & ~misaligned;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg       <= IDLE;
      timeout_cnt_reg <= '0;
      wb_reg          <= '0;
      mem_req_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      mem_byte_en_reg <= '0;
      ld_size_reg     <= '0;
      ld_lane_reg     <= '0;
      ld_signed_reg   <= 1'b0;
      align_err_reg   <= 1'b0;
      bus_err_reg     <= 1'b0;
    end else begin
      align_err_reg <= 1'b0;
      bus_err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (memop && !misaligned) begin
            state_reg       <= ACCESS;
            timeout_cnt_reg <= '0;
            wb_reg          <= '0;
            mem_req_reg     <= 1'b1;
            mem_we_reg      <= MemWriteIn;
            mem_addr_reg    <= {ALUIn[31:2], 2'b00};
            mem_wdata_reg   <= st_wdata;
            mem_byte_en_reg <= st_byte_en;
            ld_size_reg     <= MemSizeIn;
            ld_lane_reg     <= ALUIn[1:0];
            ld_signed_reg   <= MemSignedIn;
          end else if (memop) begin
            wb_reg        <= '0;
            align_err_reg <= 1'b1;
          end else begin
            wb_reg <= in_bundle;
          end
        end
        ACCESS: begin
          if (MemAck || timeout_hit) begin
            state_reg       <= IDLE;
            timeout_cnt_reg <= '0;
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            mem_byte_en_reg <= '0;
            wb_reg          <= MemAck ? in_bundle : '0;
            bus_err_reg     <= ~MemAck;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + TIMEOUT_CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign MemReq            = mem_req_reg;
  assign MemWe             = mem_we_reg;
  assign MemAddr           = mem_addr_reg;
  assign MemWData          = mem_wdata_reg;
  assign MemByteEn         = mem_byte_en_reg;
  assign RegWriteOut       = wb_reg.reg_write;
  assign MemToRegOut       = wb_reg.mem_to_reg;
  assign JumpOut           = wb_reg.jump;
  assign ALUOut            = wb_reg.alu;
  assign MemoryReadDataOut = wb_reg.read_data;
  assign DestinationRegOut = wb_reg.dest;
  assign PCValueForJALOut  = wb_reg.pc_link;
  assign AlignErrOut       = align_err_reg;
  assign BusErrOut         = bus_err_reg;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed testbench for memory_access_stage: one task per scenario, inline checks,
// memory side driven by hand (TIMEOUT_CYCLES = 4).
module tb_memory_access_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ValidIn, FlushIn, RegWriteIn, MemToRegIn;
  logic [1:0]  JumpIn;
  logic        MemReadIn, MemWriteIn;
  logic [1:0]  MemSizeIn;
  logic        MemSignedIn;
  logic [31:0] ALUIn, StoreDataIn;
  logic [4:0]  DestinationRegIn;
  logic [31:0] PCValueForJALIn;
  logic        StallOut, MemReq, MemWe;
  logic [31:0] MemAddr, MemWData;
  logic [3:0]  MemByteEn;
  logic [31:0] MemRData;
  logic        MemAck;
  logic        RegWriteOut, MemToRegOut;
  logic [1:0]  JumpOut;
  logic [31:0] ALUOut, MemoryReadDataOut;
  logic [4:0]  DestinationRegOut;
  logic [31:0] PCValueForJALOut;
  logic        AlignErrOut, BusErrOut;

  int errors = 0;
  int checks = 0;

  // Back-to-back load vectors: address, size, signed, read data, expected result.
  logic [31:0] b2b_addr  [3] = '{32'h0000_0010, 32'h0000_0011, 32'h0000_0012};
  logic [1:0]  b2b_size  [3] = '{2'b00, 2'b10, 2'b01};
  logic        b2b_sign  [3] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] b2b_rdata [3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8001_0000};
  logic [31:0] b2b_exp   [3] = '{32'hDEAD_BEEF, 32'h0000_00BE, 32'hFFFF_8001};

  always #5 Clk = ~Clk;

  memory_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .Clk(Clk), .Rst(Rst), .ValidIn(ValidIn), .FlushIn(FlushIn),
    .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn), .JumpIn(JumpIn),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn), .MemSizeIn(MemSizeIn),
    .MemSignedIn(MemSignedIn), .ALUIn(ALUIn), .StoreDataIn(StoreDataIn),
    .DestinationRegIn(DestinationRegIn), .PCValueForJALIn(PCValueForJALIn),
    .StallOut(StallOut), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemByteEn(MemByteEn), .MemRData(MemRData), .MemAck(MemAck),
    .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut), .JumpOut(JumpOut),
    .ALUOut(ALUOut), .MemoryReadDataOut(MemoryReadDataOut),
    .DestinationRegOut(DestinationRegOut), .PCValueForJALOut(PCValueForJALOut),
    .AlignErrOut(AlignErrOut), .BusErrOut(BusErrOut)
  );

  task automatic idle_inputs();
    ValidIn = 0; FlushIn = 0; RegWriteIn = 0; MemToRegIn = 0; JumpIn = 0;
    MemReadIn = 0; MemWriteIn = 0; MemSizeIn = 0; MemSignedIn = 0;
    ALUIn = 0; StoreDataIn = 0; DestinationRegIn = 0; PCValueForJALIn = 0;
  endtask

  task automatic test_reset();
    Rst = 1; idle_inputs(); MemAck = 0; MemRData = 0;
    repeat (2) @(negedge Clk);
    checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL reset_memreq: got %b want 0", MemReq); end
    checks++; if (MemWe !== 1'b0) begin errors++; $display("FAIL reset_memwe: got %b want 0", MemWe); end
    checks++; if (MemByteEn !== 4'b0) begin errors++; $display("FAIL reset_byteen: got %b want 0000", MemByteEn); end
    checks++; if (RegWriteOut !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", RegWriteOut); end
    checks++; if (ALUOut !== 32'h0) begin errors++; $display("FAIL reset_aluout: got %h want 0", ALUOut); end
    checks++; if ({AlignErrOut, BusErrOut, StallOut} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {AlignErrOut, BusErrOut, StallOut}); end
    @(negedge Clk); Rst = 0;
    $display("reset: outputs cleared");
  endtask

  task automatic test_alu_op();
    @(negedge Clk);
    idle_inputs(); ValidIn = 1; RegWriteIn = 1; ALUIn = 32'h1234; DestinationRegIn = 5;
    PCValueForJALIn = 32'h44; JumpIn = 2'b01;
    #1;
    checks++; if (StallOut !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", StallOut); end
    @(negedge Clk);
    checks++; if (RegWriteOut !== 1'b1) begin errors++; $display("FAIL alu_regwrite: got %b want 1", RegWriteOut); end
    checks++; if (ALUOut !== 32'h1234) begin errors++; $display("FAIL alu_aluout: got %h want 00001234", ALUOut); end
    checks++; if (DestinationRegOut !== 5'd5) begin errors++; $display("FAIL alu_dest: got %0d want 5", DestinationRegOut); end
    checks++; if ({JumpOut, PCValueForJALOut} !== {2'b01, 32'h44}) begin errors++; $display("FAIL alu_link: got %b/%h want 01/00000044", JumpOut, PCValueForJALOut); end
    FlushIn = 1; ALUIn = 32'h55;
    @(negedge Clk);
    checks++; if (RegWriteOut !== 1'b0) begin errors++; $display("FAIL alu_flush_regwrite: got %b want 0", RegWriteOut); end
    checks++; if (ALUOut !== 32'h55) begin errors++; $display("FAIL alu_flush_aluout: got %h want 00000055", ALUOut); end
    idle_inputs();
    $display("alu op: ALUIn=00001234 dest=5, then flushed op");
  endtask

  task automatic test_load_byte_signed();
    int stalls = 0;
    @(negedge Clk);
    idle_inputs(); ValidIn = 1; RegWriteIn = 1; MemToRegIn = 1; MemReadIn = 1;
    MemSizeIn = 2'b10; MemSignedIn = 1; ALUIn = 32'h103; DestinationRegIn = 7; MemAck = 0;
    #1; if (StallOut) stalls++;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); #1;
      if (StallOut) stalls++;
      if (i == 0) begin
        checks++; if ({MemReq, MemWe} !== 2'b10) begin errors++; $display("FAIL lb_req: got req/we %b want 10", {MemReq, MemWe}); end
        checks++; if (MemAddr !== 32'h100) begin errors++; $display("FAIL lb_addr: got %h want 00000100", MemAddr); end
        checks++; if (RegWriteOut !== 1'b0) begin errors++; $display("FAIL lb_bubble: got %b want 0", RegWriteOut); end
      end
    end
    @(negedge Clk); MemAck = 1; MemRData = 32'h8012_3456;
    #1; if (StallOut) stalls++;
    checks++; if (stalls !== 4) begin errors++; $display("FAIL lb_stall_cycles: got %0d want 4", stalls); end
    @(negedge Clk); MemAck = 0; idle_inputs();
    checks++; if (MemoryReadDataOut !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", MemoryReadDataOut); end
    checks++; if ({RegWriteOut, MemToRegOut, DestinationRegOut} !== {2'b11, 5'd7}) begin errors++; $display("FAIL lb_bundle: got %b want 1100111", {RegWriteOut, MemToRegOut, DestinationRegOut}); end
    checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL lb_req_drop: got %b want 0", MemReq); end
    $display("lb signed addr=00000103: read=%h", MemoryReadDataOut);
  endtask

  task automatic test_store_half();
    @(negedge Clk);
    idle_inputs(); ValidIn = 1; MemWriteIn = 1; MemSizeIn = 2'b01; ALUIn = 32'h102;
    StoreDataIn = 32'hCAFE_BEEF; MemAck = 0;
    #1;
    checks++; if (StallOut !== 1'b1) begin errors++; $display("FAIL sh_stall: got %b want 1", StallOut); end
    @(negedge Clk);
    checks++; if ({MemReq, MemWe} !== 2'b11) begin errors++; $display("FAIL sh_req: got req/we %b want 11", {MemReq, MemWe}); end
    checks++; if (MemByteEn !== 4'b1100) begin errors++; $display("FAIL sh_byteen: got %b want 1100", MemByteEn); end
    checks++; if (MemWData !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata: got %h want beefbeef", MemWData); end
    checks++; if (MemAddr !== 32'h100) begin errors++; $display("FAIL sh_addr: got %h want 00000100", MemAddr); end
    FlushIn = 1;
    @(negedge Clk); #1;
    checks++; if ({MemReq, StallOut, MemByteEn} !== 6'b11_1100) begin errors++; $display("FAIL sh_flush_ignored: got req/stall/be %b want 111100", {MemReq, StallOut, MemByteEn}); end
    MemAck = 1; MemRData = 32'hFFFF_FFFF;
    @(negedge Clk); MemAck = 0; idle_inputs();
    checks++; if ({MemReq, MemWe} !== 2'b00) begin errors++; $display("FAIL sh_req_drop: got %b want 00", {MemReq, MemWe}); end
    checks++; if (MemoryReadDataOut !== 32'h0) begin errors++; $display("FAIL sh_rdata_zero: got %h want 0", MemoryReadDataOut); end
    checks++; if (ALUOut !== 32'h102) begin errors++; $display("FAIL sh_aluout: got %h want 00000102", ALUOut); end
    $display("sh addr=00000102 data=beef: completed");
  endtask

  task automatic test_store_byte();
    @(negedge Clk);
    idle_inputs(); ValidIn = 1; MemWriteIn = 1; MemSizeIn = 2'b10; ALUIn = 32'h101;
    StoreDataIn = 32'h1234_56A5; MemAck = 0;
    @(negedge Clk);
    checks++; if (MemByteEn !== 4'b0010) begin errors++; $display("FAIL sb_byteen: got %b want 0010", MemByteEn); end
    checks++; if (MemWData !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h want a5a5a5a5", MemWData); end
    MemAck = 1;
    @(negedge Clk); MemAck = 0; idle_inputs();
    checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL sb_req_drop: got %b want 0", MemReq); end
    $display("sb addr=00000101 data=a5: completed");
  endtask

  task automatic test_misaligned();
    @(negedge Clk);
    idle_inputs(); ValidIn = 1; RegWriteIn = 1; MemReadIn = 1; MemSizeIn = 2'b00; ALUIn = 32'h102;
    #1;
    checks++; if (StallOut !== 1'b0) begin errors++; $display("FAIL align_stall: got %b want 0", StallOut); end
    @(negedge Clk);
    checks++; if ({MemReq, AlignErrOut, RegWriteOut} !== 3'b010) begin errors++; $display("FAIL align_pulse: got req/err/rw %b want 010", {MemReq, AlignErrOut, RegWriteOut}); end
    idle_inputs();
    @(negedge Clk);
    checks++; if (AlignErrOut !== 1'b0) begin errors++; $display("FAIL align_one_pulse: got %b want 0", AlignErrOut); end
    $display("lw addr=00000102: alignment error");
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    logic last_stall = 1'b1;
    @(negedge Clk);
    idle_inputs(); ValidIn = 1; RegWriteIn = 1; MemReadIn = 1; ALUIn = 32'h200; MemAck = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk); #1;
      if (MemReq) begin
        req_cycles++;
        last_stall = StallOut;
      end else begin
        break;
      end
    end
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
    checks++; if (last_stall !== 1'b0) begin errors++; $display("FAIL to_stall_release: got %b want 0", last_stall); end
    checks++; if ({BusErrOut, RegWriteOut} !== 2'b10) begin errors++; $display("FAIL to_buserr: got err/rw %b want 10", {BusErrOut, RegWriteOut}); end
    idle_inputs();
    @(negedge Clk);
    checks++; if ({BusErrOut, MemReq} !== 2'b00) begin errors++; $display("FAIL to_one_pulse: got err/req %b want 00", {BusErrOut, MemReq}); end
    $display("lw addr=00000200 no ack: bus error after %0d request cycles", req_cycles);
  endtask

  task automatic test_reset_mid_access();
    @(negedge Clk);
    idle_inputs(); ValidIn = 1; RegWriteIn = 1; MemWriteIn = 1; ALUIn = 32'h300;
    StoreDataIn = 32'h1111_2222; MemAck = 0;
    @(negedge Clk);
    checks++; if (MemReq !== 1'b1) begin errors++; $display("FAIL rst_mid_req: got %b want 1", MemReq); end
    Rst = 1;
    @(negedge Clk);
    idle_inputs();
    #1;
    checks++; if ({MemReq, MemWe, MemByteEn} !== 6'b0) begin errors++; $display("FAIL rst_mid_drop: got req/we/be %b want 000000", {MemReq, MemWe, MemByteEn}); end
    checks++; if ({MemAddr, MemWData} !== 64'h0) begin errors++; $display("FAIL rst_mid_bus: got %h/%h want 0/0", MemAddr, MemWData); end
    checks++; if (StallOut !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b want 0", StallOut); end
    Rst = 0;
    @(negedge Clk);
    checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got %b want 0", MemReq); end
    $display("reset during store addr=00000300: request dropped");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      if (k > 0) begin
        checks++; if (MemoryReadDataOut !== b2b_exp[k-1]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", k - 1, MemoryReadDataOut, b2b_exp[k-1]); end
      end
      // Ack held high through the IDLE cycle must not complete anything early.
      idle_inputs(); ValidIn = 1; RegWriteIn = 1; MemToRegIn = 1; MemReadIn = 1;
      MemSizeIn = b2b_size[k]; MemSignedIn = b2b_sign[k]; ALUIn = b2b_addr[k];
      DestinationRegIn = 5'(k + 10); MemAck = 1; MemRData = b2b_rdata[k];
      #1;
      checks++; if ({MemReq, StallOut} !== 2'b01) begin errors++; $display("FAIL b2b_idle%0d: got req/stall %b want 01", k, {MemReq, StallOut}); end
      @(negedge Clk); #1;
      checks++; if ({MemReq, StallOut} !== 2'b10) begin errors++; $display("FAIL b2b_access%0d: got req/stall %b want 10", k, {MemReq, StallOut}); end
      checks++; if (MemAddr !== {b2b_addr[k][31:2], 2'b00}) begin errors++; $display("FAIL b2b_addr%0d: got %h want %h", k, MemAddr, {b2b_addr[k][31:2], 2'b00}); end
      $display("b2b load %0d addr=%h", k, b2b_addr[k]);
    end
    @(negedge Clk); MemAck = 0; idle_inputs();
    checks++; if (MemoryReadDataOut !== b2b_exp[2]) begin errors++; $display("FAIL b2b_data2: got %h want %h", MemoryReadDataOut, b2b_exp[2]); end
    checks++; if (DestinationRegOut !== 5'd12) begin errors++; $display("FAIL b2b_dest: got %0d want 12", DestinationRegOut); end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load_byte_signed();
    test_store_half();
    test_store_byte();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
